key_repeat_conditioner: RTL and testbench
=========================================

KEY_REPEAT_CONDITIONER -- requirements
Module: key_repeat_conditioner

Interface
REQ-001 Parameter DEB_CNT, default 500000, is the number of consecutive stable cycles required to accept a level change (10 ms at 50 MHz).
REQ-002 Parameter REPEAT_DELAY, default 25000000, is the number of cycles from the o_press cycle to the first o_repeat (0.5 s).
REQ-003 Parameter REPEAT_PERIOD, default 5000000, is the number of cycles between successive o_repeat pulses (0.1 s).
REQ-004 The design SHALL use one clock; reset is synchronous and active-high.
REQ-005 i_clk  input  1  system clock (CLOCK_50 domain); all state changes on its rising edge.
REQ-006 i_rst  input  1  synchronous reset, active-high.
REQ-007 i_key  input  1  raw push-button, active-low, asynchronous to i_clk.
REQ-008 i_repeat_en  input  1  1 enables auto-repeat; 0 suppresses it.
REQ-009 o_level  output  1  debounced key state, 1 = pressed.
REQ-010 o_press  output  1  one-cycle pulse on each debounced press.
REQ-011 o_release  output  1  one-cycle pulse on each debounced release.
REQ-012 o_repeat  output  1  one-cycle pulse for each auto-repeat.
REQ-013 o_event  output  1  o_press OR o_repeat, used to drive the start/left/right strobes of the game core.
REQ-014 o_repeat_cnt  output  8  number of repeats since the last press, saturating.

Function
REQ-015 i_key SHALL pass through a 2-flop synchronizer before any other use; both flops reset to 1.
REQ-016 Debounce counter: it SHALL increment each cycle the synchronized input differs from the debounced state, and clear to 0 in any cycle they match.
REQ-017 On the DEB_CNT-th consecutive differing cycle, the debounced state SHALL take the synchronized value at the next edge and the counter SHALL clear.
REQ-018 o_level SHALL be the inverse of the debounced state; o_press/o_release SHALL be registered and high exactly in the first cycle of the new debounced level.
REQ-019 The repeat FSM SHALL have states IDLE, DELAY and REPEAT, each with a cycle counter of 25 bits minimum.
REQ-020 IDLE -> DELAY in the o_press cycle, with counter = 0.
REQ-021 DELAY: the counter SHALL increment each cycle; when counter = REPEAT_DELAY-1, o_repeat SHALL pulse next cycle and the FSM SHALL go to REPEAT with counter = 0.
REQ-022 REPEAT: o_repeat SHALL pulse every REPEAT_PERIOD cycles.
REQ-023 A debounced release in any state SHALL force IDLE in the o_release cycle; no o_repeat SHALL be emitted in or after that cycle.
REQ-024 If i_repeat_en = 0, the FSM SHALL hold in or return to IDLE, with no o_repeat; o_press/o_release SHALL be unaffected.
REQ-025 If i_repeat_en rises while the key is held, repeat SHALL NOT start until the next press.
REQ-026 o_repeat_cnt SHALL clear to 0 on o_press, increment on each o_repeat, saturate at 255, and hold its value after release.
REQ-027 o_press and o_repeat SHALL never be high in the same cycle; o_event SHALL therefore be a single pulse per event.
REQ-028 Glitches shorter than DEB_CNT cycles SHALL produce no output change.

Reset
REQ-029 While i_rst = 1 at an edge, the synchronizer and debounced state SHALL become 1 (released), counters 0, FSM IDLE, and all outputs 0 from the next cycle.
REQ-030 Reset asserted mid-hold or mid-repeat SHALL abort without emitting o_release; after reset, a still-held key SHALL be re-debounced and produce a fresh o_press.

Verification (DEB_CNT=4, REPEAT_DELAY=10, REPEAT_PERIOD=3; edge 0 = first edge sampling i_key=0)
REQ-031 Clean press, hold 40 cycles, release -> o_press in cycle 6; o_repeat in cycles 16, 19, 22, ...; o_release exactly once; o_repeat_cnt equals the number of repeats emitted.
REQ-032 i_key low for 3 cycles, then high -> no o_press, o_level stays 0.
REQ-033 Bounce pattern 0,1,0,0,1 followed by a steady 0 -> exactly one o_press, 4 cycles after the steady level begins at the synchronizer output.
REQ-034 Hold with i_repeat_en=0 for 100 cycles -> one o_press, zero o_repeat, o_repeat_cnt=0.
REQ-035 Hold 1000 cycles -> o_repeat_cnt saturates at 255, with no wrap.
REQ-036 i_rst pulsed during REPEAT with the key held -> outputs 0 the cycle after reset, no o_release, and a new o_press DEB_CNT+2 cycles after reset deasserts.

Source files
------------

// File: rtl/key_repeat_conditioner.sv
// key_repeat_conditioner
//   Turns a raw, bouncing, active-low push-button into clean key events for
//   the game core: a debounced level, one-cycle press/release pulses, and
//   auto-repeat pulses while the key stays held.
//
// Ports
//   i_clk         system clock; all state changes on its rising edge
//   i_rst         synchronous reset, active-high
//   i_key         raw push-button, active-low, asynchronous to i_clk
//   i_repeat_en   1 enables auto-repeat, 0 suppresses it
//   o_level       debounced key state, 1 = pressed
//   o_press       one-cycle pulse on each debounced press
//   o_release     one-cycle pulse on each debounced release
//   o_repeat      one-cycle pulse for each auto-repeat
//   o_event       o_press OR o_repeat (start/left/right strobe)
//   o_repeat_cnt  repeats since the last press, saturating at 255
module key_repeat_conditioner #(
  parameter int DEB_CNT       = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_key,
  input  logic       i_repeat_en,
  output logic       o_level,
  output logic       o_press,
  output logic       o_release,
  output logic       o_repeat,
  output logic       o_event,
  output logic [7:0] o_repeat_cnt
);

  // The debounce counter never exceeds DEB_CNT-1: it clears on acceptance.
  localparam int DEB_W  = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam int RPT_MX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W  = ($clog2(RPT_MX) > 25) ? $clog2(RPT_MX) : 25;

  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CNT - 1);
  localparam logic [DEB_W-1:0] DEB_ONE    = DEB_W'(1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_LAST   = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic             key_sync_p0;
  logic             key_sync_p1;
  logic             deb_state;     // 1 = released (raw polarity)
  logic [DEB_W-1:0] deb_cnt;
  logic             accept;
  logic             press_now;
  logic             release_now;

  rpt_state_t       state, state_nxt;
  logic [RPT_W-1:0] rpt_cnt, rpt_cnt_nxt;
  logic             repeat_nxt;

  // Acceptance happens on the DEB_CNT-th consecutive differing cycle; the
  // pulses are registered at the same edge the debounced level flips, so
  // they line up with the first cycle of the new level.
  assign accept      = (key_sync_p1 != deb_state) && (deb_cnt == DEB_LAST);
  assign press_now   = accept && !key_sync_p1;
  assign release_now = accept &&  key_sync_p1;

  // Stage p0/p1: synchronizer, then debounce.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      key_sync_p0 <= 1'b1;
      key_sync_p1 <= 1'b1;
      deb_state   <= 1'b1;
      deb_cnt     <= '0;
    end else begin
      key_sync_p0 <= i_key;
      key_sync_p1 <= key_sync_p0;
      if (key_sync_p1 == deb_state) begin
        deb_cnt <= '0;
      end else if (accept) begin
        deb_state <= key_sync_p1;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_ONE;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    rpt_cnt_nxt = rpt_cnt;
    repeat_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (press_now) begin
          state_nxt   = DELAY;
          rpt_cnt_nxt = '0;
        end
      end
      DELAY: begin
        if (rpt_cnt == DELAY_LAST) begin
          repeat_nxt  = 1'b1;
          state_nxt   = REPEAT;
          rpt_cnt_nxt = '0;
        end else begin
          rpt_cnt_nxt = rpt_cnt + RPT_ONE;
        end
      end
      REPEAT: begin
        if (rpt_cnt == PER_LAST) begin
          repeat_nxt  = 1'b1;
          rpt_cnt_nxt = '0;
        end else begin
          rpt_cnt_nxt = rpt_cnt + RPT_ONE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        rpt_cnt_nxt = '0;
      end
    endcase
    // Release or a disabled repeat wins over everything, including a repeat
    // that would otherwise fire in this same cycle. Because IDLE is only left
    // on a press, enabling repeat mid-hold waits for the next press.
    if (release_now || !i_repeat_en) begin
      state_nxt   = IDLE;
      rpt_cnt_nxt = '0;
      repeat_nxt  = 1'b0;
    end
  end

  // Stage p2: repeat FSM and registered event outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      rpt_cnt      <= '0;
      o_press      <= 1'b0;
      o_release    <= 1'b0;
      o_repeat     <= 1'b0;
      o_repeat_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      rpt_cnt   <= rpt_cnt_nxt;
      o_press   <= press_now;
      o_release <= release_now;
      o_repeat  <= repeat_nxt;
      if (press_now) begin
        o_repeat_cnt <= 8'd0;
      end else if (repeat_nxt) begin
        o_repeat_cnt <= sat_inc8(o_repeat_cnt);
      end
    end
  end

  assign o_level = ~deb_state;
  assign o_event = o_press | o_repeat;

endmodule

// File: tb/tb_key_repeat_conditioner.sv
// Bench for key_repeat_conditioner with small timing parameters.
// Expected press/release/repeat events (kind + cycle) are queued when the
// key stimulus is driven and popped by a monitor whenever the DUT emits one.
module tb_key_repeat_conditioner;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  localparam int K_PRESS   = 1;
  localparam int K_RELEASE = 2;
  localparam int K_REPEAT  = 4;

  logic       clk;
  logic       rst;
  logic       key;
  logic       en;
  logic       o_level;
  logic       o_press;
  logic       o_release;
  logic       o_repeat;
  logic       o_event;
  logic [7:0] o_repeat_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int kind;
    int cyc;
  } evt_t;

  evt_t exp_q[$];
  evt_t mon_e;
  int   mon_kind;

  key_repeat_conditioner #(
    .DEB_CNT      (DEB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_key       (key),
    .i_repeat_en (en),
    .o_level     (o_level),
    .o_press     (o_press),
    .o_release   (o_release),
    .o_repeat    (o_repeat),
    .o_event     (o_event),
    .o_repeat_cnt(o_repeat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input int k, input int c);
    evt_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Press for n cycles (measured at the pin), then release and settle.
  task automatic hold_key(input int n, input bit rep_on);
    int c;
    c   = cyc;
    key = 1'b0;
    push(K_PRESS, c + DEB + 2);
    if (rep_on)
      for (int t = c + DEB + 2 + RD; t < c + n + DEB + 2; t += RP)
        push(K_REPEAT, t);
    push(K_RELEASE, c + n + DEB + 2);
    step(n / 2);
    check("hold_level", int'(o_level), 1);
    step(n - n / 2);
    key = 1'b1;
    step(20);
    check("after_release_level", int'(o_level), 0);
    check("q_empty", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin : monitor
    mon_kind = int'({o_repeat, o_release, o_press});
    if (mon_kind != 0) begin
      if (exp_q.size() == 0) begin
        check("spurious_evt", mon_kind, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("evt_kind", mon_kind, mon_e.kind);
        check("evt_cycle", cyc, mon_e.cyc);
        check("evt_or", int'(o_event), (mon_e.kind != K_RELEASE) ? 1 : 0);
      end
    end else if (o_event) begin
      check("spurious_event_out", 1, 0);
    end
  end

  initial begin
    int c;
    int r;
    logic [4:0] bounce;

    rst = 1'b1;
    key = 1'b1;
    en  = 1'b1;
    step(3);
    check("rst_level", int'(o_level), 0);
    check("rst_press", int'(o_press), 0);
    check("rst_cnt", int'(o_repeat_cnt), 0);
    rst = 1'b0;
    step(5);
    check("idle_level", int'(o_level), 0);

    // Clean press, 40-cycle hold, release.
    hold_key(40, 1'b1);
    check("s1_cnt", int'(o_repeat_cnt), 10);

    // 3-cycle glitch is ignored.
    key = 1'b0;
    step(3);
    key = 1'b1;
    step(20);
    check("glitch_level", int'(o_level), 0);
    check("glitch_q", exp_q.size(), 0);

    // Long hold saturates the repeat counter.
    hold_key(1000, 1'b1);
    check("sat_cnt", int'(o_repeat_cnt), 255);

    // Bounce 0,1,0,0,1 then steady low.
    bounce = 5'b10010;
    for (int i = 0; i < 5; i++) begin
      key = bounce[i];
      step(1);
    end
    key = 1'b0;
    c   = cyc;
    push(K_PRESS, c + DEB + 2);
    step(8);
    push(K_RELEASE, cyc + DEB + 2);
    key = 1'b1;
    step(20);
    check("bounce_q", exp_q.size(), 0);
    check("bounce_cnt", int'(o_repeat_cnt), 0);

    // Repeat disabled for a 100-cycle hold.
    en = 1'b0;
    hold_key(100, 1'b0);
    check("noen_cnt", int'(o_repeat_cnt), 0);

    // Enable rises mid-hold: no repeat until the next press.
    c   = cyc;
    key = 1'b0;
    push(K_PRESS, c + DEB + 2);
    step(20);
    en = 1'b1;
    step(40);
    push(K_RELEASE, cyc + DEB + 2);
    key = 1'b1;
    step(20);
    check("enrise_cnt", int'(o_repeat_cnt), 0);
    check("enrise_q", exp_q.size(), 0);

    // Reset during REPEAT with the key held.
    c   = cyc;
    key = 1'b0;
    push(K_PRESS, c + DEB + 2);
    push(K_REPEAT, c + 16);
    push(K_REPEAT, c + 19);
    push(K_REPEAT, c + 22);
    step(23);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    r   = cyc;
    push(K_PRESS, r + DEB + 2);
    @(negedge clk);
    check("mrst_level", int'(o_level), 0);
    check("mrst_press", int'(o_press), 0);
    check("mrst_release", int'(o_release), 0);
    check("mrst_repeat", int'(o_repeat), 0);
    check("mrst_event", int'(o_event), 0);
    check("mrst_cnt", int'(o_repeat_cnt), 0);
    // Release lands exactly where the first repeat would have fired.
    step(10);
    push(K_RELEASE, cyc + DEB + 2);
    key = 1'b1;
    step(20);
    check("mrst_final_level", int'(o_level), 0);
    check("mrst_final_cnt", int'(o_repeat_cnt), 0);

    check("final_q", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
